// File: rtl/decade_counter_ctrl.sv
// Run/pause/clear controller for a three-digit BCD counter chain, saturating at 999.
// Optional lap snapshot register is built when DECADE_CTRL_LAP_EN is defined.
module decade_counter_ctrl #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  input  logic [3:0]  ones,
  input  logic [3:0]  tens,
  input  logic [3:0]  hundreds,
  output logic        cnt_enable,
  output logic        cnt_clr_n,
  output logic        running,
  output logic        overflow,
  output logic [11:0] lap_bcd,
  output logic        lap_valid
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVF   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          clr_n_q, clr_n_d;
  logic          running_q, overflow_q;
  logic          tick;
  logic          terminal;

  assign terminal = (hundreds == 4'd9) && (tens == 4'd9) && (ones == 4'd9);
  assign tick     = (state_q == RUN) && (presc_q == PRESC_LAST);

  // A stop or clear in the tick cycle must not let the chain advance.
  assign cnt_enable = tick && !terminal && !stop && !clear;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    clr_n_d = 1'b1;
    if (clear) begin
      state_d = IDLE;
      presc_d = '0;
      clr_n_d = 1'b0;
    end else if (stop && (state_q == RUN)) begin
      state_d = PAUSE;
    end else if (start && ((state_q == IDLE) || (state_q == PAUSE))) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (terminal) begin
          state_d = OVF;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      clr_n_q    <= 1'b1;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      clr_n_q    <= clr_n_d;
      running_q  <= (state_d == RUN);
      overflow_q <= (state_d == OVF);
    end
  end

  assign cnt_clr_n = clr_n_q;
  assign running   = running_q;
  assign overflow  = overflow_q;

`ifdef DECADE_CTRL_LAP_EN
  logic [11:0] lap_bcd_q;
  logic        lap_valid_q;

  // Captures the digits as presented before this edge's increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_bcd_q   <= '0;
      lap_valid_q <= 1'b0;
    end else if (clear) begin
      lap_bcd_q   <= '0;
      lap_valid_q <= 1'b0;
    end else if (lap) begin
      lap_bcd_q   <= {hundreds, tens, ones};
      lap_valid_q <= 1'b1;
    end else begin
      lap_valid_q <= 1'b0;
    end
  end

  assign lap_bcd   = lap_bcd_q;
  assign lap_valid = lap_valid_q;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign lap_bcd    = 12'h000;
  assign lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_decade_counter_ctrl.sv
// Scoreboard bench for decade_counter_ctrl with TICK_DIV=4 and a behavioural BCD chain.
// Expectations are queued per cycle by the stimulus and consumed by independent monitors.
module tb_decade_counter_ctrl;

  localparam int TICK_DIV = 4;
  localparam int SIG_RUNNING   = 0;
  localparam int SIG_OVERFLOW  = 1;
  localparam int SIG_CLR_N     = 2;
  localparam int SIG_CHAIN     = 3;
  localparam int SIG_LAP_BCD   = 4;
  localparam int SIG_LAP_VALID = 5;
  localparam int SIG_ENABLE    = 6;

  typedef struct {
    int          cycle;
    int          sig;
    logic [11:0] expVal;
    string       name;
  } check_t;

  logic        clk;
  logic        reset_n;
  logic        start, stop, clear, lap;
  logic [3:0]  ones, tens, hundreds;
  logic        cntEnable, cntClrN, running, overflow, lapValid;
  logic [11:0] lapBcd;
  logic        chainRst_n;
  logic        loadEn;
  logic [11:0] loadVal;

  int     cycleCount  = 0;
  int     testsRun    = 0;
  int     testsFailed = 0;
  check_t checkQ[$];
  int     enableQ[$];
  event   sampleNow;

  decade_counter_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .lap       (lap),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .cnt_enable(cntEnable),
    .cnt_clr_n (cntClrN),
    .running   (running),
    .overflow  (overflow),
    .lap_bcd   (lapBcd),
    .lap_valid (lapValid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Behavioural counter chain: the system reset and the controller clear both zero it.
  assign chainRst_n = reset_n & cntClrN;
  always @(posedge clk or negedge chainRst_n) begin
    if (!chainRst_n) begin
      {hundreds, tens, ones} <= 12'h000;
    end else if (loadEn) begin
      {hundreds, tens, ones} <= loadVal;
    end else if (cntEnable) begin
      if (ones == 4'd9) begin
        ones <= 4'd0;
        if (tens == 4'd9) begin
          tens     <= 4'd0;
          hundreds <= (hundreds == 4'd9) ? 4'd0 : hundreds + 4'd1;
        end else begin
          tens <= tens + 4'd1;
        end
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

  task automatic checkOutput(input check_t c);
    logic [11:0] actual;
    case (c.sig)
      SIG_RUNNING:   actual = {11'd0, running};
      SIG_OVERFLOW:  actual = {11'd0, overflow};
      SIG_CLR_N:     actual = {11'd0, cntClrN};
      SIG_CHAIN:     actual = {hundreds, tens, ones};
      SIG_LAP_BCD:   actual = lapBcd;
      SIG_LAP_VALID: actual = {11'd0, lapValid};
      SIG_ENABLE:    actual = {11'd0, cntEnable};
      default:       actual = 'x;
    endcase
    testsRun++;
    if (actual !== c.expVal) begin
      testsFailed++;
      $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", c.name, cycleCount, actual, c.expVal);
    end
  endtask

  task automatic scanChecks(input bit asyncPhase);
    check_t keep[$];
    foreach (checkQ[i]) begin
      if ((asyncPhase && checkQ[i].cycle == -1) || (!asyncPhase && checkQ[i].cycle == cycleCount)) begin
        checkOutput(checkQ[i]);
      end else if (!asyncPhase && checkQ[i].cycle >= 0 && checkQ[i].cycle < cycleCount) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: got no sample, expected one in cycle %0d", checkQ[i].name, checkQ[i].cycle);
      end else begin
        keep.push_back(checkQ[i]);
      end
    end
    checkQ = keep;
  endtask

  initial forever begin
    @(negedge clk);
    scanChecks(1'b0);
  end

  initial forever begin
    @(sampleNow);
    scanChecks(1'b1);
  end

  // Every enable pulse must match a queued cycle; queued cycles that pass unseen are misses.
  initial forever begin
    @(negedge clk);
    while (enableQ.size() > 0 && enableQ[0] < cycleCount) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL enable_missed: got no pulse, expected pulse in cycle %0d", enableQ[0]);
      void'(enableQ.pop_front());
    end
    if (cntEnable === 1'b1) begin
      testsRun++;
      if (enableQ.size() > 0 && enableQ[0] == cycleCount) begin
        void'(enableQ.pop_front());
      end else begin
        testsFailed++;
        $display("[TB] FAIL enable_unexpected: got pulse in cycle %0d, expected none", cycleCount);
      end
    end
  end

  task automatic expectAt(input int cyc, input int sig, input logic [11:0] v, input string nm);
    check_t c;
    c.cycle  = cyc;
    c.sig    = sig;
    c.expVal = v;
    c.name   = nm;
    checkQ.push_back(c);
  endtask

  task automatic expectEnable(input int cyc);
    enableQ.push_back(cyc);
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic waitEdges(input int n);
    for (int i = 0; i < n; i++) waitEdge();
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic c, input logic l);
    start = s;
    stop  = p;
    clear = c;
    lap   = l;
    waitEdge();
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    lap   = 1'b0;
  endtask

  task automatic loadChain(input logic [11:0] v);
    loadVal = v;
    loadEn  = 1'b1;
    waitEdge();
    loadEn  = 1'b0;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, r, c, l, s, k, e;
    reset_n = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    clear   = 1'b0;
    lap     = 1'b0;
    loadEn  = 1'b0;
    loadVal = 12'h000;

    waitEdges(2);
    expectAt(-1, SIG_RUNNING,   12'h0, "reset_running");
    expectAt(-1, SIG_OVERFLOW,  12'h0, "reset_overflow");
    expectAt(-1, SIG_CLR_N,     12'h1, "reset_clr_n");
    expectAt(-1, SIG_ENABLE,    12'h0, "reset_enable");
    expectAt(-1, SIG_LAP_BCD,   12'h0, "reset_lap_bcd");
    expectAt(-1, SIG_LAP_VALID, 12'h0, "reset_lap_valid");
    ->sampleNow;
    #1;
    reset_n = 1'b1;
    waitEdge();
    expectAt(cycleCount, SIG_RUNNING, 12'h0, "idle_after_reset");

    $display("[TB] counting");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    n = cycleCount;
    expectAt(n, SIG_RUNNING, 12'h1, "start_running");
    expectEnable(n + 3);
    expectEnable(n + 7);
    expectEnable(n + 11);
    expectAt(n + 12, SIG_CHAIN, 12'h003, "count_after_12");
    waitEdges(14);

    $display("[TB] pause and resume");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    expectAt(cycleCount, SIG_RUNNING, 12'h0, "stop_pauses");
    expectAt(cycleCount, SIG_CHAIN, 12'h003, "chain_held_after_stop");
    waitEdges(10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    r = cycleCount;
    expectAt(r, SIG_RUNNING, 12'h1, "resume_running");
    expectEnable(r + 1);
    expectAt(r + 2, SIG_CHAIN, 12'h004, "count_after_resume");
    waitEdges(2);

    $display("[TB] simultaneous commands");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    expectAt(cycleCount, SIG_RUNNING, 12'h0, "stop_beats_start");
    expectAt(cycleCount, SIG_CHAIN, 12'h004, "chain_held_in_pause");
    waitEdges(4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    c = cycleCount;
    expectAt(c, SIG_CLR_N, 12'h0, "clear_pulse");
    expectAt(c, SIG_RUNNING, 12'h0, "clear_beats_start");
    expectAt(c, SIG_CHAIN, 12'h000, "clear_zeroes_chain");
    expectAt(c + 1, SIG_CLR_N, 12'h1, "clear_pulse_one_cycle");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectAt(cycleCount, SIG_RUNNING, 12'h1, "start_after_clear");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    expectAt(cycleCount, SIG_RUNNING, 12'h0, "stop_after_clear");
    waitEdges(2);

    $display("[TB] lap");
    loadChain(12'h123);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    l = cycleCount;
`ifdef DECADE_CTRL_LAP_EN
    expectAt(l, SIG_LAP_BCD, 12'h123, "lap_capture");
    expectAt(l, SIG_LAP_VALID, 12'h1, "lap_valid_pulse");
    expectAt(l + 1, SIG_LAP_VALID, 12'h0, "lap_valid_one_cycle");
    expectAt(l + 1, SIG_LAP_BCD, 12'h123, "lap_held");
`else
    expectAt(l, SIG_LAP_BCD, 12'h000, "lap_disabled_bcd");
    expectAt(l, SIG_LAP_VALID, 12'h0, "lap_disabled_valid");
`endif
    waitEdges(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    c = cycleCount;
    expectAt(c, SIG_LAP_BCD, 12'h000, "clear_beats_lap_bcd");
    expectAt(c, SIG_LAP_VALID, 12'h0, "clear_beats_lap_valid");
    expectAt(c, SIG_CHAIN, 12'h000, "clear_with_lap_chain");
    waitEdge();

    $display("[TB] saturation");
    loadChain(12'h998);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    s = cycleCount;
    expectEnable(s + 3);
    expectAt(s + 4, SIG_CHAIN, 12'h999, "reach_999");
    expectAt(s + 7, SIG_ENABLE, 12'h0, "terminal_tick_suppressed");
    expectAt(s + 7, SIG_RUNNING, 12'h1, "running_before_ovf");
    expectAt(s + 8, SIG_OVERFLOW, 12'h1, "overflow_set");
    expectAt(s + 8, SIG_RUNNING, 12'h0, "ovf_not_running");
    expectAt(s + 8, SIG_CHAIN, 12'h999, "chain_holds_999");
    waitEdges(9);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectAt(cycleCount, SIG_OVERFLOW, 12'h1, "start_ignored_in_ovf");
    expectAt(cycleCount, SIG_RUNNING, 12'h0, "start_ignored_running");
    waitEdges(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    k = cycleCount;
    expectAt(k, SIG_OVERFLOW, 12'h0, "clear_leaves_ovf");
    expectAt(k, SIG_CHAIN, 12'h000, "clear_from_ovf_chain");
    expectAt(k, SIG_RUNNING, 12'h0, "clear_from_ovf_running");
    waitEdge();

    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitEdges(2);
    reset_n = 1'b0;
    #1;
    expectAt(-1, SIG_RUNNING, 12'h0, "midrun_reset_running");
    expectAt(-1, SIG_OVERFLOW, 12'h0, "midrun_reset_overflow");
    expectAt(-1, SIG_CLR_N, 12'h1, "midrun_reset_clr_n");
    expectAt(-1, SIG_ENABLE, 12'h0, "midrun_reset_enable");
    ->sampleNow;
    #1;
    waitEdge();
    reset_n = 1'b1;
    waitEdge();
    e = cycleCount;
    expectAt(e, SIG_RUNNING, 12'h0, "idle_after_midrun_reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    n = cycleCount;
    expectEnable(n + 3);
    expectAt(n + 4, SIG_CHAIN, 12'h001, "prescaler_restarted");
    waitEdges(6);

    testsRun++;
    if (enableQ.size() != 0 || checkQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL pending_expectations: got %0d enable and %0d value entries left, expected 0",
               enableQ.size(), checkQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
